// File: rtl/rc_scheduler_pkg.sv
// Shared NoC router types: output-port encoding and per-VC route-computation states.
package noc_params;

    localparam int unsigned VC_NUM = 2;

    typedef enum logic [2:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANTED,
        ROUTED
    } rc_state_t;

endpackage

// File: rtl/rc_scheduler_rc_unit.sv
// Combinational XY dimension-order routing: resolve X first, then Y, else deliver locally.
module rc_unit
    import noc_params::*;
#(
    parameter int unsigned DEST_ADDR_SIZE_X = 3,
    parameter int unsigned DEST_ADDR_SIZE_Y = 3,
    parameter int unsigned X_CURRENT        = 2,
    parameter int unsigned Y_CURRENT        = 3
) (
    input  logic [DEST_ADDR_SIZE_X-1:0] x_dest,
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
    output port_t                       out_port_c
);

    localparam logic [DEST_ADDR_SIZE_X-1:0] X_CUR = DEST_ADDR_SIZE_X'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE_Y-1:0] Y_CUR = DEST_ADDR_SIZE_Y'(Y_CURRENT);

    always_comb begin
        out_port_c = LOCAL;
        if (x_dest < X_CUR) begin
            out_port_c = WEST;
        end else if (x_dest > X_CUR) begin
            out_port_c = EAST;
        end else if (y_dest < Y_CUR) begin
            out_port_c = NORTH;
        end else if (y_dest > Y_CUR) begin
            out_port_c = SOUTH;
        end
    end

endmodule

// File: rtl/rc_scheduler.sv
// Per-input-port route-computation scheduler: per-VC state machines sharing one rc_unit
// through a round-robin arbiter and a single-entry pipeline stage.
module rc_scheduler
    import noc_params::*;
#(
    parameter int unsigned VC_NUM           = 2,
    parameter int unsigned DEST_ADDR_SIZE_X = 3,
    parameter int unsigned DEST_ADDR_SIZE_Y = 3,
    parameter int unsigned X_CURRENT        = 2,
    parameter int unsigned Y_CURRENT        = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [VC_NUM-1:0]                       req_i,
    input  logic [VC_NUM-1:0][DEST_ADDR_SIZE_X-1:0] x_dest_i,
    input  logic [VC_NUM-1:0][DEST_ADDR_SIZE_Y-1:0] y_dest_i,
    input  logic [VC_NUM-1:0]                       release_i,
    output logic [VC_NUM-1:0]                       route_valid_o,
    output port_t [VC_NUM-1:0]                      out_port_o
);

    localparam int unsigned VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    typedef struct packed {
        logic                        valid;
        vc_idx_t                     vc;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    } stage_t;

    rc_state_t [VC_NUM-1:0]                 state_q, state_d;
    logic [VC_NUM-1:0][DEST_ADDR_SIZE_X-1:0] x_q, x_d;
    logic [VC_NUM-1:0][DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
    vc_idx_t                                rr_ptr_q, rr_ptr_d;
    stage_t                                 stage_q, stage_d;
    logic [VC_NUM-1:0]                      route_valid_d;
    port_t [VC_NUM-1:0]                     out_port_d;

    logic                                   grant_vld_c;
    vc_idx_t                                grant_vc_c;
    vc_idx_t                                scan_idx_c;
    port_t                                  rc_port_c;

    // Round-robin arbiter: first WAIT VC at or after rr_ptr, with wrap-around.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_vc_c  = '0;
        scan_idx_c  = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            scan_idx_c = vc_idx_t'((32'(rr_ptr_q) + i) % VC_NUM);
            if (!grant_vld_c && state_q[scan_idx_c] == WAIT) begin
                grant_vld_c = 1'b1;
                grant_vc_c  = scan_idx_c;
            end
        end
    end

    // Next-state logic for all VCs, pointer, pipeline stage and registered outputs.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        rr_ptr_d      = rr_ptr_q;
        stage_d       = '0;
        route_valid_d = '0;
        out_port_d    = out_port_o;

        for (int unsigned v = 0; v < VC_NUM; v++) begin
            case (state_q[v])
                IDLE: begin
                    if (req_i[v]) begin
                        state_d[v] = WAIT;
                        x_d[v]     = x_dest_i[v];
                        y_d[v]     = y_dest_i[v];
                    end
                end
                WAIT: begin
                    if (grant_vld_c && grant_vc_c == vc_idx_t'(v)) begin
                        state_d[v] = GRANTED;
                    end
                end
                GRANTED: begin
                    state_d[v] = ROUTED;
                end
                ROUTED: begin
                    // A release with a new request chains straight into the next packet.
                    if (release_i[v]) begin
                        if (req_i[v]) begin
                            state_d[v] = WAIT;
                            x_d[v]     = x_dest_i[v];
                            y_d[v]     = y_dest_i[v];
                        end else begin
                            state_d[v] = IDLE;
                        end
                    end
                end
                default: begin
                    state_d[v] = IDLE;
                end
            endcase
            route_valid_d[v] = (state_d[v] == ROUTED);
        end

        if (grant_vld_c) begin
            rr_ptr_d       = vc_idx_t'((32'(grant_vc_c) + 32'd1) % VC_NUM);
            stage_d.valid  = 1'b1;
            stage_d.vc     = grant_vc_c;
            stage_d.x_dest = x_q[grant_vc_c];
            stage_d.y_dest = y_q[grant_vc_c];
        end

        if (stage_q.valid) begin
            out_port_d[stage_q.vc] = rc_port_c;
        end
    end

    rc_unit #(
        .DEST_ADDR_SIZE_X (DEST_ADDR_SIZE_X),
        .DEST_ADDR_SIZE_Y (DEST_ADDR_SIZE_Y),
        .X_CURRENT        (X_CURRENT),
        .Y_CURRENT        (Y_CURRENT)
    ) u_rc_unit (
        .x_dest     (stage_q.x_dest),
        .y_dest     (stage_q.y_dest),
        .out_port_c (rc_port_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                state_q[v]    <= IDLE;
                out_port_o[v] <= LOCAL;
            end
            x_q           <= '0;
            y_q           <= '0;
            rr_ptr_q      <= '0;
            stage_q       <= '0;
            route_valid_o <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rr_ptr_q      <= rr_ptr_d;
            stage_q       <= stage_d;
            route_valid_o <= route_valid_d;
            out_port_o    <= out_port_d;
        end
    end

endmodule

// File: tb/tb_rc_scheduler.sv
// Self-checking bench for rc_scheduler: directed scenarios plus random traffic against a
// cycle-level behavioural model of the per-VC routing rules.
module tb_rc_scheduler;
    import noc_params::*;

    localparam int NVC = 2;
    localparam int XW  = 3;
    localparam int YW  = 3;
    localparam int XC  = 2;
    localparam int YC  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NVC-1:0]          req;
    logic [NVC-1:0]          rel;
    logic [NVC-1:0][XW-1:0]  xd;
    logic [NVC-1:0][YW-1:0]  yd;
    logic [NVC-1:0]          rv;
    port_t [NVC-1:0]         op;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    // Model state: 0 idle, 1 waiting, 2 route being computed, 3 routed.
    int m_ph   [NVC];
    int m_x    [NVC];
    int m_y    [NVC];
    int m_port [NVC];
    int m_ptr;

    rc_scheduler #(
        .VC_NUM           (NVC),
        .DEST_ADDR_SIZE_X (XW),
        .DEST_ADDR_SIZE_Y (YW),
        .X_CURRENT        (XC),
        .Y_CURRENT        (YC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .x_dest_i      (xd),
        .y_dest_i      (yd),
        .release_i     (rel),
        .route_valid_o (rv),
        .out_port_o    (op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int xy(input int x, input int y);
        if (x < XC) return int'(WEST);
        if (x > XC) return int'(EAST);
        if (y < YC) return int'(NORTH);
        if (y > YC) return int'(SOUTH);
        return int'(LOCAL);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model, advanced on each rising edge from the inputs of the ending cycle.
    initial begin : model
        int win;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int v = 0; v < NVC; v++) begin
                    m_ph[v]   = 0;
                    m_port[v] = int'(LOCAL);
                end
                m_ptr = 0;
            end else begin
                win = -1;
                for (int k = 0; k < NVC; k++) begin
                    if (win < 0 && m_ph[(m_ptr + k) % NVC] == 1) win = (m_ptr + k) % NVC;
                end
                for (int v = 0; v < NVC; v++) begin
                    if (m_ph[v] == 0) begin
                        if (req[v]) begin
                            m_ph[v] = 1;
                            m_x[v]  = int'(xd[v]);
                            m_y[v]  = int'(yd[v]);
                        end
                    end else if (m_ph[v] == 1) begin
                        if (v == win) m_ph[v] = 2;
                    end else if (m_ph[v] == 2) begin
                        m_ph[v]   = 3;
                        m_port[v] = xy(m_x[v], m_y[v]);
                    end else if (rel[v]) begin
                        m_ph[v] = req[v] ? 1 : 0;
                        if (req[v]) begin
                            m_x[v] = int'(xd[v]);
                            m_y[v] = int'(yd[v]);
                        end
                    end
                end
                if (win >= 0) m_ptr = (win + 1) % NVC;
            end
        end
    end

    // Compare process: every cycle, valid must match the model and routed ports must agree.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (run) begin
                for (int v = 0; v < NVC; v++) begin
                    chk($sformatf("model_valid%0d", v), int'(rv[v]), int'(m_ph[v] == 3));
                    if (m_ph[v] == 3) chk($sformatf("model_port%0d", v), int'(op[v]), m_port[v]);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rel = '0;
        tick();
        rst = 1'b0;
    endtask

    // Sole request on VC v in cycle 0; also holds req in ROUTED to show it is ignored.
    task automatic single_route(input int v, input int x, input int y, input int exp, input string name);
        req[v] = 1'b1;
        xd[v]  = XW'(x);
        yd[v]  = YW'(y);
        tick();
        req[v] = 1'b0;
        tick();
        chk({name, "_c2_valid"}, int'(rv[v]), 0);
        tick();
        chk({name, "_c3_valid"}, int'(rv[v]), 1);
        chk({name, "_port"}, int'(op[v]), exp);
        req[v] = 1'b1;
        xd[v]  = XW'(x ^ 7);
        tick();
        chk({name, "_hold_valid"}, int'(rv[v]), 1);
        chk({name, "_hold_port"}, int'(op[v]), exp);
        req[v] = 1'b0;
        rel[v] = 1'b1;
        tick();
        rel[v] = 1'b0;
        chk({name, "_released"}, int'(rv[v]), 0);
    endtask

    initial begin : main
        logic [NVC-1:0] prev;
        int             gap [NVC];
        int             rises [NVC];

        rst = 1'b1;
        req = '0;
        rel = '0;
        xd  = '0;
        yd  = '0;
        tick();
        tick();
        chk("reset_valid", int'(rv), 0);
        chk("reset_port0", int'(op[0]), int'(LOCAL));
        chk("reset_port1", int'(op[1]), int'(LOCAL));
        chk("reset_rr_ptr", int'(dut.rr_ptr_q), 0);
        rst = 1'b0;
        run = 1'b1;

        // Hand-computed routing expectations.
        single_route(0, 0, 3, int'(WEST),  "west");
        single_route(0, 2, 3, int'(LOCAL), "local");
        single_route(1, 2, 6, int'(SOUTH), "south");
        single_route(1, 4, 0, int'(EAST),  "east_xfirst");

        // Simultaneous requests; VC1's early release while still waiting must be ignored.
        do_reset();
        req   = 2'b11;
        xd[0] = 3'd4;
        yd[0] = 3'd3;
        xd[1] = 3'd2;
        yd[1] = 3'd0;
        tick();
        req = 2'b00;
        rel = 2'b10;
        tick();
        tick();
        rel = 2'b00;
        chk("simul_c3_valid", int'(rv), 1);
        chk("simul_port0", int'(op[0]), int'(EAST));
        tick();
        chk("simul_c4_valid", int'(rv), 3);
        chk("simul_port1", int'(op[1]), int'(NORTH));
        chk("simul_rr_ptr", int'(dut.rr_ptr_q), 0);
        rel = 2'b11;
        tick();
        rel = 2'b00;
        chk("simul_released", int'(rv), 0);

        // Reset arrives while VC0's route is being computed.
        do_reset();
        req[0] = 1'b1;
        xd[0]  = 3'd0;
        yd[0]  = 3'd3;
        tick();
        req[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", int'(rv), 0);
        chk("midrst_port0", int'(op[0]), int'(LOCAL));
        chk("midrst_rr_ptr", int'(dut.rr_ptr_q), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_no_valid", int'(rv[0]), 0);
        end

        // Fairness: both VCs chain release+req every time they are routed.
        do_reset();
        xd[0] = 3'd0;
        yd[0] = 3'd0;
        xd[1] = 3'd5;
        yd[1] = 3'd5;
        req   = 2'b11;
        prev  = '0;
        for (int v = 0; v < NVC; v++) begin
            gap[v]   = 0;
            rises[v] = 0;
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("fair_not_both_rise", int'((rv & ~prev) == 2'b11), 0);
            for (int v = 0; v < NVC; v++) begin
                if (rv[v] && !prev[v]) begin
                    chk("fair_gap_le3", int'(gap[v] <= 3), 1);
                    rises[v]++;
                    gap[v] = 0;
                end
                if (!rv[v]) gap[v]++;
            end
            prev = rv;
            req  = rv;
            rel  = rv;
        end
        chk("fair_balance", int'(rises[0] - rises[1] <= 1 && rises[1] - rises[0] <= 1), 1);
        chk("fair_progress", int'(rises[0] >= 8), 1);

        // Random traffic checked by the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req = NVC'($urandom);
            rel = NVC'($urandom_range(0, 3) & $urandom_range(0, 3));
            for (int v = 0; v < NVC; v++) begin
                xd[v] = XW'($urandom);
                yd[v] = YW'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        rel = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc_scheduler.md
# rc_scheduler

Route-computation scheduler for one input port. It tracks the routing state of each virtual channel (VC) and shares a single combinational `rc_unit` among all VCs through a round-robin arbiter. Each VC's computed output port is held until the VC releases it. The block sits between the VC buffers, which raise requests on head flits and release on tail flits, and switch/VC allocation, which consumes `route_valid_o` and `out_port_o`.

## Interface
Parameters:
- `VC_NUM`, default 2: number of VCs served; must be ≥ 1.
- `DEST_ADDR_SIZE_X`, default 3: width of the X destination field.
- `DEST_ADDR_SIZE_Y`, default 3: width of the Y destination field.
- `X_CURRENT`, default 2: X coordinate of this router.
- `Y_CURRENT`, default 3: Y coordinate of this router.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  VC_NUM  per VC: a head flit awaits routing; sampled only in IDLE or ROUTED.
- `x_dest_i`  in  VC_NUM × DEST_ADDR_SIZE_X  per-VC destination X; captured together with an accepted request.
- `y_dest_i`  in  VC_NUM × DEST_ADDR_SIZE_Y  per-VC destination Y; captured together with an accepted request.
- `release_i`  in  VC_NUM  per VC: the tail flit has left, so the route is freed; honoured only in ROUTED.
- `route_valid_o`  out  VC_NUM  per VC: high while the VC is in ROUTED.
- `out_port_o`  out  VC_NUM × port_t  per-VC registered output port; meaningful only while `route_valid_o` is high.

## Operation
Each VC has its own state machine with four states: IDLE, WAIT, GRANTED and ROUTED.

State transitions:
- IDLE with `req_i[v]` → WAIT; the destination is captured into a per-VC register.
- WAIT:
  - eligible for arbitration;
  - when granted → GRANTED;
  - otherwise stays in WAIT.
- GRANTED → ROUTED unconditionally on the next edge; `out_port_o[v]` is written from the `rc_unit` result on that edge.
- ROUTED:
  - `release_i[v]` alone → IDLE;
  - `release_i[v]` and `req_i[v]` together → WAIT, capturing the new destination (back-to-back packets);
  - `req_i[v]` without release is ignored.

Ignored inputs:
- `release_i` outside ROUTED.
- `req_i` in WAIT or GRANTED.

Arbiter:
- Round-robin pointer `rr_ptr`, range 0..VC_NUM-1.
- The winner is the first VC in WAIT, scanning from `rr_ptr` upward with wrap-around.
- At most one grant per cycle.
- After a grant, `rr_ptr` becomes the winner index + 1, modulo VC_NUM. With no grant, `rr_ptr` holds.

Pipeline stage (one entry):
- On a grant, the stage register loads `{valid=1, vc index, x_dest, y_dest}`.
- Otherwise `valid` is 0.
- `rc_unit` reads the stage register's destination.
- XY routing rule:
  - X differs: WEST if the destination is smaller, EAST if larger;
  - X equal: NORTH if Y is smaller, SOUTH if larger, LOCAL if equal.

## Timing
- Reset values:
  - all VCs IDLE;
  - `rr_ptr` = 0;
  - stage `valid` = 0;
  - `route_valid_o` = 0;
  - every `out_port_o` = LOCAL.
- Latency for a sole requester, with `req_i[v]` high in cycle 0:
  - WAIT in cycle 1 (arbitration);
  - GRANTED in cycle 2 (route computed);
  - `route_valid_o[v]` high from cycle 3.
- Throughput: one route completed per cycle across all VCs.
- Worst-case wait for a VC in WAIT: VC_NUM−1 cycles before its grant.
- `route_valid_o[v]` and `out_port_o[v]` stay stable through ROUTED until the edge that samples `release_i[v]`; from the next cycle `route_valid_o[v]` is 0.
- `rst` during any cycle overrides all other inputs, including an in-flight GRANTED entry: the route is discarded and no later `route_valid_o` pulse appears for it.
- VC_NUM = 1: `rr_ptr` is constantly 0, and the latency is unchanged.

## Structure
- `noc_params` gains:
  - `typedef enum {IDLE, WAIT, GRANTED, ROUTED} rc_state_t`;
  - `VC_NUM`, if not already exported.
- `noc_params` already supplies `port_t` (LOCAL, NORTH, SOUTH, WEST, EAST); it is reused unchanged.
- Sub-module: one instance of the existing `rc_unit`, fed by the stage register.
- The arbiter and the per-VC state machines are inline; no other sub-modules.

## Test plan
All tests use X_CURRENT=2, Y_CURRENT=3, VC_NUM=2.
- Single request: VC0 requests dest (0,3) in cycle 0 → `route_valid_o` = 2'b01 from cycle 3, `out_port_o[0]` = WEST; it holds until `release_i[0]`, then clears the next cycle.
- Simultaneous requests: VC0 dest (4,3) and VC1 dest (2,0) in the same cycle →
  - VC0 gets EAST, valid from cycle 3;
  - VC1 gets NORTH, valid from cycle 4;
  - `rr_ptr` = 0 afterwards.
- Fairness: both VCs re-request with release+req every time they reach ROUTED → grants alternate VC0, VC1, VC0…; neither waits more than 1 cycle in WAIT.
- Routing boundaries: dest (2,3) → LOCAL; (2,6) → SOUTH; (4,0) → EAST, since X takes priority.
- Reset mid-flight: `rst` asserted in the cycle VC0 is GRANTED → next cycle all outputs are at reset values, and no VC0 valid appears in the following 5 cycles.
- Ignored inputs:
  - `req_i[0]` held in ROUTED without release → `out_port_o[0]` unchanged;
  - `release_i[1]` while VC1 is in WAIT → VC1 is still routed on schedule.
